// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing a single ALU: accept, execute, respond.
// Optional ALU_ARB_ROUND_ROBIN_EN swaps fixed port-0 priority for round-robin.

module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out
);

  logic [DATA_WIDTH:0] sum_s;
  logic [DATA_WIDTH:0] diff_s;
  logic                slt_s;

  // Combinational ALU; the top bit of diff_s is the unsigned borrow.
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    diff_s    = {1'b0, a} - {1'b0, b};
    slt_s     = ($signed(a) < $signed(b));
    result    = {DATA_WIDTH{1'b0}};
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (op)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010: begin
        result    = sum_s[DATA_WIDTH-1:0];
        overflow  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                    (sum_s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        carry_out = sum_s[DATA_WIDTH];
      end
      3'b110: begin
        result    = diff_s[DATA_WIDTH-1:0];
        overflow  = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                    (diff_s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        carry_out = diff_s[DATA_WIDTH];
      end
      3'b111: result = {{(DATA_WIDTH-1){1'b0}}, slt_s};
      default: result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_A0,
  input  logic [DATA_WIDTH-1:0] req_B0,
  input  logic [DATA_WIDTH-1:0] req_A1,
  input  logic [DATA_WIDTH-1:0] req_B1,
  input  logic [2:0]            req_ALUop0,
  input  logic [2:0]            req_ALUop1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_Result,
  output logic                  resp_Zero,
  output logic                  resp_Overflow,
  output logic                  resp_CarryOut,
  output logic                  resp_err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  logic [1:0]            state_r;
  logic                  owner_r;
  logic                  run_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [2:0]            op_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  zero_r;
  logic                  ovf_r;
  logic                  carry_r;
  logic                  err_r;
  logic [1:0]            resp_valid_r;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic                  rr_r;
`endif

  logic [1:0]            grant_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic                  alu_ovf_s;
  logic                  alu_co_s;
  logic [DATA_WIDTH-1:0] res_s;
  logic                  ovf_s;
  logic                  co_s;
  logic                  zero_s;
  logic                  err_s;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a         (a_r),
    .b         (b_r),
    .op        (op_r),
    .result    (alu_res_s),
    .overflow  (alu_ovf_s),
    .carry_out (alu_co_s)
  );

  // Grant selection; run_r keeps req_ready low until the first edge after reset.
  always_comb begin
    grant_s = 2'b00;
    if (run_r && (state_r == ST_IDLE)) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req_valid == 2'b11) begin
        grant_s = rr_r ? 2'b10 : 2'b01;
      end else begin
        grant_s = req_valid;
      end
`else
      if (req_valid[0]) begin
        grant_s = 2'b01;
      end else if (req_valid[1]) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b00;
      end
`endif
    end else begin
      grant_s = 2'b00;
    end
  end

  assign accept_s  = |(req_valid & grant_s);
  assign req_ready = grant_s;

  // Mask ALU outputs: flags only for ADD/SUB, illegal ops return a zero result.
  always_comb begin
    err_s = ~op_legal(op_r);
    if (err_s) begin
      res_s = {DATA_WIDTH{1'b0}};
    end else begin
      res_s = alu_res_s;
    end
    if ((op_r == 3'b010) || (op_r == 3'b110)) begin
      ovf_s = alu_ovf_s;
      co_s  = alu_co_s;
    end else begin
      ovf_s = 1'b0;
      co_s  = 1'b0;
    end
    zero_s = (res_s == {DATA_WIDTH{1'b0}});
  end

  // Reset-release qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_r <= 1'b0;
    else        run_r <= 1'b1;
  end

  // Control FSM, owner and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      a_r     <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
      op_r    <= 3'b000;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_EXEC;
            owner_r <= grant_s[1];
            a_r     <= grant_s[1] ? req_A1 : req_A0;
            b_r     <= grant_s[1] ? req_B1 : req_B0;
            op_r    <= grant_s[1] ? req_ALUop1 : req_ALUop0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_r    <= ~grant_s[1];
`endif
          end
        end
        ST_EXEC: state_r <= ST_RESP;
        ST_RESP: begin
          if (resp_ready[owner_r]) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Response register: loaded only in EXEC, valid cleared on the owner's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r     <= {DATA_WIDTH{1'b0}};
      zero_r       <= 1'b0;
      ovf_r        <= 1'b0;
      carry_r      <= 1'b0;
      err_r        <= 1'b0;
      resp_valid_r <= 2'b00;
    end else if (state_r == ST_EXEC) begin
      result_r     <= res_s;
      zero_r       <= zero_s;
      ovf_r        <= ovf_s;
      carry_r      <= co_s;
      err_r        <= err_s;
      resp_valid_r <= owner_r ? 2'b10 : 2'b01;
    end else if ((state_r == ST_RESP) && resp_ready[owner_r]) begin
      resp_valid_r <= 2'b00;
    end
  end

  assign resp_valid    = resp_valid_r;
  assign resp_Result   = result_r;
  assign resp_Zero     = zero_r;
  assign resp_Overflow = ovf_r;
  assign resp_CarryOut = carry_r;
  assign resp_err      = err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ops, flags, hold, arbitration order, reset abort.

module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_A0, req_B0, req_A1, req_B1;
  logic [2:0]  req_ALUop0, req_ALUop1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_Result;
  logic        resp_Zero, resp_Overflow, resp_CarryOut, resp_err;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_A0        (req_A0),
    .req_B0        (req_B0),
    .req_A1        (req_A1),
    .req_B1        (req_B1),
    .req_ALUop0    (req_ALUop0),
    .req_ALUop1    (req_ALUop1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_Result   (resp_Result),
    .resp_Zero     (resp_Zero),
    .resp_Overflow (resp_Overflow),
    .resp_CarryOut (resp_CarryOut),
    .resp_err      (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
    chk({tag, "_resp_valid"}, {62'd0, resp_valid}, 64'd0);
    chk({tag, "_result"}, {32'd0, resp_Result}, 64'd0);
    chk({tag, "_flags"}, {60'd0, resp_Zero, resp_Overflow, resp_CarryOut, resp_err}, 64'd0);
  endtask

  // One full transaction with resp_ready already high; ends in IDLE at t+3.
  task automatic run_op(input string tag, input int port, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op, input logic [31:0] er,
                        input logic ez, input logic eov, input logic eco, input logic eerr);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if (port == 1) begin
      req_A1 = a; req_B1 = b; req_ALUop1 = op;
    end else begin
      req_A0 = a; req_B0 = b; req_ALUop0 = op;
    end
    req_valid  = oh;
    resp_ready = oh;
    #1 chk({tag, "_req_ready_t"}, {62'd0, req_ready}, {62'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, "_req_ready_exec"}, {62'd0, req_ready}, 64'd0);
    chk({tag, "_resp_valid_exec"}, {62'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_resp_valid"}, {62'd0, resp_valid}, {62'd0, oh});
    chk({tag, "_result"}, {32'd0, resp_Result}, {32'd0, er});
    chk({tag, "_flags_zocE"}, {60'd0, resp_Zero, resp_Overflow, resp_CarryOut, resp_err},
        {60'd0, ez, eov, eco, eerr});
    @(negedge clk);
    chk({tag, "_resp_valid_done"}, {62'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    int exp_port;
    int cnt0;
    int cnt1;
    logic [31:0] exp_res;

    rst_n = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    req_A0 = 32'd0; req_B0 = 32'd0; req_A1 = 32'd0; req_B1 = 32'd0;
    req_ALUop0 = 3'b000; req_ALUop1 = 3'b000;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    req_valid = 2'b00;
    rst_n = 1'b1;

    run_op("add_ovf", 0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_borrow", 1, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("slt_neg", 1, 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("or", 0, 32'h1200_0034, 32'h0056_0000, 3'b001, 32'h1256_0034, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_carry_zero", 0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 0, 32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("slt_false", 0, 32'h0000_0005, 32'hFFFF_FFFF, 3'b111, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Response held for 5 cycles while both ports request.
    @(negedge clk);
    req_A0 = 32'h0000_F0F0; req_B0 = 32'h0000_FF00; req_ALUop0 = 3'b000;
    req_valid = 2'b01;
    resp_ready = 2'b00;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("hold_resp_valid_t2", {62'd0, resp_valid}, 64'd1);
    chk("hold_result_t2", {32'd0, resp_Result}, 64'h0000_F000);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", {62'd0, resp_valid}, 64'd1);
      chk("hold_result", {32'd0, resp_Result}, 64'h0000_F000);
      chk("hold_req_ready", {62'd0, req_ready}, 64'd0);
    end
    req_valid = 2'b00;
    resp_ready = 2'b10;
    @(negedge clk);
    chk("hold_wrong_port_ready", {62'd0, resp_valid}, 64'd1);
    resp_ready = 2'b01;
    @(negedge clk);
    chk("hold_released", {62'd0, resp_valid}, 64'd0);
    req_valid = 2'b01;
    #1 chk("idle_after_release", {62'd0, req_ready}, 64'd1);
    req_valid = 2'b00;
    @(negedge clk);
    chk("withdrawn_no_resp", {62'd0, resp_valid}, 64'd0);

    run_op("illegal_100", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("illegal_011", 0, 32'h0000_0001, 32'h0000_0002, 3'b011, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("illegal_101", 1, 32'h0000_0001, 32'h0000_0002, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Both ports request continuously; port 0 computes 1+1, port 1 computes 10+20.
    @(negedge clk);
    req_A0 = 32'd1;  req_B0 = 32'd1;  req_ALUop0 = 3'b010;
    req_A1 = 32'd10; req_B1 = 32'd20; req_ALUop1 = 3'b010;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = (i < 4) ? 0 : 1;
`endif
      exp_res = (exp_port == 1) ? 32'd30 : 32'd2;
      #1 chk("arb_grant", {62'd0, req_ready}, (exp_port == 1) ? 64'd2 : 64'd1);
      @(negedge clk);
      if (req_ready == 2'b00) begin
        if (exp_port == 1) cnt1++;
        else               cnt0++;
      end
      if (cnt0 == 4) req_valid[0] = 1'b0;
      if (cnt1 == 4) req_valid[1] = 1'b0;
      @(negedge clk);
      chk("arb_resp_valid", {62'd0, resp_valid}, (exp_port == 1) ? 64'd2 : 64'd1);
      chk("arb_result", {32'd0, resp_Result}, {32'd0, exp_res});
      @(negedge clk);
    end
    chk("arb_drained", {62'd0, resp_valid}, 64'd0);
    req_valid = 2'b00;

    // Reset pulsed during EXEC aborts the operation.
    @(negedge clk);
    req_A0 = 32'd7; req_B0 = 32'd8; req_ALUop0 = 3'b010;
    req_valid = 2'b01;
    resp_ready = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", {62'd0, resp_valid}, 64'd0);
    end
    run_op("after_reset", 0, 32'h0000_00F0, 32'h0000_003C, 3'b000, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
